// File: rtl/dog_extrema_detector_pkg.sv
// ============================================================================
//  dog_extrema_detector_pkg : shared state encoding and sizing helpers
//  Rev 1.0
// ============================================================================
`default_nettype none

package dog_extrema_detector_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dog_line_buffer.sv
// ============================================================================
//  dog_line_buffer : 1R1W RAM holding two previous-row taps per column
//  Rev 1.0
// ============================================================================
`default_nettype none

module dog_line_buffer #(
    parameter int DEPTH = 400,
    parameter int WIDTH = 16,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register only moves on an advance so stalls keep the tap aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dog_extrema_detector.sv
// ============================================================================
//  dog_extrema_detector : streaming 3x3 DoG extremum detector, one out per in
//  Rev 1.0
// ============================================================================
`default_nettype none

module dog_extrema_detector
    import dog_extrema_detector_pkg::*;
#(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300,
    parameter int DATA_WIDTH = 8,
    parameter int THRESH     = 8,
    parameter int MARK_VALUE = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  valid,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  kp,
    output logic                  valid_out,
    input  logic                  rd_en,
    output logic                  frame_done,
    output logic [15:0]           kp_count
);

    localparam int W  = IMG_WIDTH;
    localparam int H  = IMG_HEIGHT;
    localparam int DW = DATA_WIDTH;
    localparam int CW = cnt_w(W);
    localparam int RW = cnt_w(H + 2);

    localparam logic [CW-1:0]   COL_LAST   = CW'(W - 1);
    localparam logic [CW-1:0]   COL_IN_MAX = CW'(W - 2);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(H - 1);
    localparam logic [RW-1:0]   ROW_IN_MAX = RW'(H - 2);
    localparam logic [RW-1:0]   ROW_ONE    = RW'(1);
    localparam logic [DW+1:0]   ZERO_X     = (DW + 2)'(2 ** (DW - 1));
    localparam logic [DW+1:0]   THR_X      = (DW + 2)'(THRESH);
    localparam logic [DW-1:0]   MARK       = DW'(MARK_VALUE);

    state_e          state_q;
    logic            run_q;
    logic [CW-1:0]   in_col_q;
    logic [RW-1:0]   in_row_q;
    logic [CW-1:0]   cen_col_q;
    logic [RW-1:0]   cen_row_q;
    logic            last_q;
    logic [DW-1:0]   win_q [3][2];
    logic [DW-1:0]   dout_q;
    logic            kp_q;
    logic            valid_out_q;
    logic            first_q;
    logic            frame_done_q;
    logic [15:0]     kp_count_q;

    logic            w_ready;
    logic            w_adv;
    logic            w_load;
    logic            w_out_xfer;
    logic [DW-1:0]   w_pix;
    logic [2*DW-1:0] w_lb_rdata;
    logic [DW-1:0]   w_col [3];
    logic [CW-1:0]   w_col_nxt;
    logic [DW-1:0]   w_centre;
    logic            w_is_max;
    logic            w_is_min;
    logic            w_inner;
    logic            w_kp;
    logic [DW+1:0]   w_cx;

    assign w_ready    = run_q && (state_q != FLUSH) && (!valid_out_q || rd_en);
    assign w_out_xfer = valid_out_q && rd_en;
    assign w_adv      = (state_q == FLUSH) ? (!last_q && (!valid_out_q || rd_en))
                                           : (valid && w_ready);
    assign w_load     = w_adv && (state_q != FILL);
    assign w_pix      = (state_q == FLUSH) ? '0 : din;
    assign w_col_nxt  = (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;

    // Incoming column: oldest row from the upper tap, newest row from the stream.
    assign w_col[0] = w_lb_rdata[2*DW-1:DW];
    assign w_col[1] = w_lb_rdata[DW-1:0];
    assign w_col[2] = w_pix;

    dog_line_buffer #(
        .DEPTH (W),
        .WIDTH (2 * DW),
        .AW    (CW)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_adv),
        .waddr_i (in_col_q),
        .wdata_i ({w_lb_rdata[DW-1:0], w_pix}),
        .re_i    (w_adv),
        .raddr_i (w_col_nxt),
        .rdata_o (w_lb_rdata)
    );

    assign w_centre = win_q[1][1];

    always_comb begin : cmp
        logic [DW-1:0] nb;
        nb       = '0;
        w_is_max = 1'b1;
        w_is_min = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                nb = (c == 2) ? w_col[r] : win_q[r][c];
                if (!(r == 1 && c == 1)) begin
                    if (nb >= w_centre) w_is_max = 1'b0;
                    if (nb <= w_centre) w_is_min = 1'b0;
                end
            end
        end
    end

    assign w_inner = (cen_row_q != '0) && (cen_row_q <= ROW_IN_MAX) &&
                     (cen_col_q != '0) && (cen_col_q <= COL_IN_MAX);
    assign w_cx    = {2'b00, w_centre};
    assign w_kp    = w_inner && ((w_is_max && (w_cx >= ZERO_X + THR_X)) ||
                                 (w_is_min && (w_cx + THR_X <= ZERO_X)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            run_q        <= 1'b0;
            in_col_q     <= '0;
            in_row_q     <= '0;
            cen_col_q    <= '0;
            cen_row_q    <= '0;
            last_q       <= 1'b0;
            dout_q       <= '0;
            kp_q         <= 1'b0;
            valid_out_q  <= 1'b0;
            first_q      <= 1'b0;
            frame_done_q <= 1'b0;
            kp_count_q   <= '0;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else begin
            run_q        <= 1'b1;
            frame_done_q <= 1'b0;

            if (w_adv) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= w_col[r];
                end
                in_col_q <= w_col_nxt;
                if (in_col_q == COL_LAST) in_row_q <= in_row_q + 1'b1;
            end

            // A fresh load always wins over draining the slot.
            if (w_load) begin
                dout_q      <= w_kp ? MARK : w_centre;
                kp_q        <= w_kp;
                valid_out_q <= 1'b1;
                first_q     <= (cen_row_q == '0) && (cen_col_q == '0);
                if (cen_col_q == COL_LAST) begin
                    cen_col_q <= '0;
                    cen_row_q <= cen_row_q + 1'b1;
                    if (cen_row_q == ROW_LAST) last_q <= 1'b1;
                end else begin
                    cen_col_q <= cen_col_q + 1'b1;
                end
            end else if (w_out_xfer) begin
                valid_out_q <= 1'b0;
            end

            if (w_out_xfer) begin
                if (first_q) begin
                    kp_count_q <= {15'd0, kp_q};
                end else if (kp_q && kp_count_q != 16'hFFFF) begin
                    kp_count_q <= kp_count_q + 16'd1;
                end
            end

            case (state_q)
                FILL: begin
                    if (w_adv && in_row_q == ROW_ONE && in_col_q == '0) state_q <= STREAM;
                end
                STREAM: begin
                    if (w_adv && in_row_q == ROW_LAST && in_col_q == COL_LAST) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (last_q && w_out_xfer) begin
                        state_q      <= FILL;
                        frame_done_q <= 1'b1;
                        in_col_q     <= '0;
                        in_row_q     <= '0;
                        cen_col_q    <= '0;
                        cen_row_q    <= '0;
                        last_q       <= 1'b0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign ready      = w_ready;
    assign dout       = dout_q;
    assign kp         = kp_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign kp_count   = kp_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dog_extrema_detector.sv
// ============================================================================
//  tb_dog_extrema_detector : frame-level self-checking bench, small 8x6 image
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_dog_extrema_detector;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int TH = 8;
    localparam int Z  = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] dout;
    logic       kp;
    logic       valid_out;
    logic       rd_en = 1'b0;
    logic       frame_done;
    logic [15:0] kp_count;

    int checks = 0;
    int failures = 0;

    int frame [N];
    int exp_dout [N];
    int exp_kp [N];
    int exp_cnt;
    int got_d [$];
    int got_k [$];
    int ref_d [$];
    int ref_k [$];
    int fd_cnt;

    always #5 clk = ~clk;

    dog_extrema_detector #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_WIDTH (8),
        .THRESH     (TH),
        .MARK_VALUE (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .valid      (valid),
        .ready      (ready),
        .dout       (dout),
        .kp         (kp),
        .valid_out  (valid_out),
        .rd_en      (rd_en),
        .frame_done (frame_done),
        .kp_count   (kp_count)
    );

    // Reference: strict 8-neighbour extremum with threshold, border excluded.
    function automatic void model();
        exp_cnt = 0;
        for (int k = 0; k < N; k++) begin
            int r = k / W;
            int c = k % W;
            int v = frame[k];
            bit gt = 1'b1;
            bit lt = 1'b1;
            bit hit = 1'b0;
            if (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2) begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) begin
                            int n = frame[(r + dr) * W + c + dc];
                            if (n >= v) gt = 1'b0;
                            if (n <= v) lt = 1'b0;
                        end
                hit = (gt && v - Z >= TH) || (lt && Z - v >= TH);
            end
            exp_kp[k]   = hit ? 1 : 0;
            exp_dout[k] = hit ? 255 : v;
            exp_cnt    += hit ? 1 : 0;
        end
    endfunction

    task automatic fill_flat();
        for (int k = 0; k < N; k++) frame[k] = Z;
    endtask

    // Streams one frame with random valid/rd_en duty and records what comes out.
    task automatic run_frame(input int vpct, input int rpct);
        int idx = 0;
        int tail = 0;
        got_d.delete();
        got_k.delete();
        fd_cnt = 0;
        for (int cyc = 0; cyc < 3000 && tail < 4; cyc++) begin
            @(negedge clk);
            valid = (idx < N) && ($urandom_range(99) < vpct);
            din   = 8'(frame[(idx < N) ? idx : 0]);
            rd_en = ($urandom_range(99) < rpct);
            #1;
            if (frame_done) fd_cnt++;
            if (valid && ready) idx++;
            if (valid_out && rd_en) begin
                got_d.push_back(int'(dout));
                got_k.push_back(int'(kp));
            end
            if (fd_cnt > 0) tail++;
        end
        @(negedge clk);
        valid = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks += 6;
        if (ready !== 1'b0)      begin failures++; $display("FAIL reset_ready got=%0b want=0", ready); end
        if (valid_out !== 1'b0)  begin failures++; $display("FAIL reset_valid_out got=%0b want=0", valid_out); end
        if (dout !== 8'd0)       begin failures++; $display("FAIL reset_dout got=%0d want=0", dout); end
        if (kp !== 1'b0)         begin failures++; $display("FAIL reset_kp got=%0b want=0", kp); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b want=0", frame_done); end
        if (kp_count !== 16'd0)  begin failures++; $display("FAIL reset_kp_count got=%0d want=0", kp_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_flat();
        fill_flat();
        model();
        run_frame(100, 100);
        checks++;
        if (got_d.size() != N) begin failures++; $display("FAIL flat_count got=%0d want=%0d", got_d.size(), N); end
        for (int k = 0; k < N && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != 128 || got_k[k] != 0) begin
                failures++; $display("FAIL flat_pix idx=%0d got=%0d/%0d want=128/0", k, got_d[k], got_k[k]);
            end
        end
        checks += 2;
        if (kp_count !== 16'd0) begin failures++; $display("FAIL flat_kp_count got=%0d want=0", kp_count); end
        if (fd_cnt != 1) begin failures++; $display("FAIL flat_frame_done got=%0d want=1", fd_cnt); end
    endtask

    task automatic test_peak();
        fill_flat();
        frame[3 * W + 4] = 200;
        model();
        run_frame(100, 100);
        checks++;
        if (got_d.size() != N) begin failures++; $display("FAIL peak_count got=%0d want=%0d", got_d.size(), N); end
        for (int k = 0; k < N && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != exp_dout[k] || got_k[k] != exp_kp[k]) begin
                failures++; $display("FAIL peak_pix idx=%0d got=%0d/%0d want=%0d/%0d", k, got_d[k], got_k[k], exp_dout[k], exp_kp[k]);
            end
        end
        checks += 3;
        if (got_d.size() > 28 && (got_d[28] != 255 || got_k[28] != 1)) begin
            failures++; $display("FAIL peak_idx28 got=%0d/%0d want=255/1", got_d[28], got_k[28]);
        end
        if (kp_count !== 16'd1) begin failures++; $display("FAIL peak_kp_count got=%0d want=1", kp_count); end
        if (fd_cnt != 1) begin failures++; $display("FAIL peak_frame_done got=%0d want=1", fd_cnt); end
        ref_d = got_d;
        ref_k = got_k;
    endtask

    task automatic test_threshold();
        fill_flat();
        frame[3 * W + 4] = 135;
        frame[2 * W + 2] = 20;
        model();
        run_frame(100, 100);
        checks++;
        if (got_d.size() != N) begin failures++; $display("FAIL thresh_count got=%0d want=%0d", got_d.size(), N); end
        for (int k = 0; k < N && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != exp_dout[k] || got_k[k] != exp_kp[k]) begin
                failures++; $display("FAIL thresh_pix idx=%0d got=%0d/%0d want=%0d/%0d", k, got_d[k], got_k[k], exp_dout[k], exp_kp[k]);
            end
        end
        checks += 2;
        if (got_d.size() > 28 && (got_d[28] != 135 || got_k[28] != 0)) begin
            failures++; $display("FAIL thresh_weak_peak got=%0d/%0d want=135/0", got_d[28], got_k[28]);
        end
        if (kp_count !== 16'd1) begin failures++; $display("FAIL thresh_kp_count got=%0d want=1", kp_count); end
    endtask

    task automatic test_border_plateau();
        fill_flat();
        frame[0 * W + 4] = 200;
        frame[3 * W + 3] = 200;
        frame[3 * W + 4] = 200;
        model();
        run_frame(100, 100);
        checks++;
        if (got_d.size() != N) begin failures++; $display("FAIL border_count got=%0d want=%0d", got_d.size(), N); end
        for (int k = 0; k < N && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != frame[k] || got_k[k] != 0) begin
                failures++; $display("FAIL border_pix idx=%0d got=%0d/%0d want=%0d/0", k, got_d[k], got_k[k], frame[k]);
            end
        end
        checks++;
        if (kp_count !== 16'd0) begin failures++; $display("FAIL border_kp_count got=%0d want=0", kp_count); end
    endtask

    task automatic test_backpressure();
        fill_flat();
        frame[3 * W + 4] = 200;
        run_frame(70, 50);
        checks++;
        if (got_d.size() != ref_d.size()) begin failures++; $display("FAIL bp_count got=%0d want=%0d", got_d.size(), ref_d.size()); end
        for (int k = 0; k < ref_d.size() && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != ref_d[k] || got_k[k] != ref_k[k]) begin
                failures++; $display("FAIL bp_pix idx=%0d got=%0d/%0d want=%0d/%0d", k, got_d[k], got_k[k], ref_d[k], ref_k[k]);
            end
        end
        checks += 2;
        if (kp_count !== 16'd1) begin failures++; $display("FAIL bp_kp_count got=%0d want=1", kp_count); end
        if (fd_cnt != 1) begin failures++; $display("FAIL bp_frame_done got=%0d want=1", fd_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < N; k++) frame[k] = int'($urandom_range(255));
        frame[2 * W + 5] = 255;
        frame[3 * W + 2] = 0;
        model();
        run_frame(80, 80);
        checks++;
        if (got_d.size() != N) begin failures++; $display("FAIL rand_count got=%0d want=%0d", got_d.size(), N); end
        for (int k = 0; k < N && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != exp_dout[k] || got_k[k] != exp_kp[k]) begin
                failures++; $display("FAIL rand_pix idx=%0d got=%0d/%0d want=%0d/%0d", k, got_d[k], got_k[k], exp_dout[k], exp_kp[k]);
            end
        end
        checks++;
        if (kp_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rand_kp_count got=%0d want=%0d", kp_count, exp_cnt); end
    endtask

    task automatic test_reset_midframe();
        int idx = 0;
        fill_flat();
        frame[3 * W + 4] = 200;
        model();
        for (int cyc = 0; cyc < 200 && idx < 20; cyc++) begin
            @(negedge clk);
            valid = 1'b1;
            rd_en = 1'b1;
            din   = 8'(frame[idx]);
            #1;
            if (valid && ready) idx++;
        end
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (idx != 20) begin failures++; $display("FAIL mid_pre_count got=%0d want=20", idx); end
        if (valid_out !== 1'b0 || ready !== 1'b0) begin
            failures++; $display("FAIL mid_reset_hs got=%0b/%0b want=0/0", valid_out, ready);
        end
        if (kp_count !== 16'd0) begin failures++; $display("FAIL mid_reset_kp_count got=%0d want=0", kp_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(100, 100);
        checks++;
        if (got_d.size() != N) begin failures++; $display("FAIL mid_count got=%0d want=%0d", got_d.size(), N); end
        for (int k = 0; k < N && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != exp_dout[k] || got_k[k] != exp_kp[k]) begin
                failures++; $display("FAIL mid_pix idx=%0d got=%0d/%0d want=%0d/%0d", k, got_d[k], got_k[k], exp_dout[k], exp_kp[k]);
            end
        end
        checks++;
        if (kp_count !== 16'd1) begin failures++; $display("FAIL mid_kp_count got=%0d want=1", kp_count); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_peak();
        test_threshold();
        test_border_plateau();
        test_backpressure();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
